xgmii_pktgen: RTL and testbench

Parametrised 10GbE test-frame generator driving one 64-bit XGMII transmit lane set in the measurement core. It emits bursts or continuous streams of Ethernet frames with configurable length and inter-frame gap, and a correct CRC-32 FCS. Every frame carries a sequence number and a transmit timestamp so a downstream RX checker can measure loss and latency. It replaces the fixed single-frame ROM generator.

---
 rtl/xgmii_pktgen_pkg.sv | 32 +++
 rtl/xgmii_pktgen_crc64.sv | 32 +++
 rtl/xgmii_pktgen.sv | 258 +++++++++++++++++++++++++
 tb/tb_xgmii_pktgen.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pktgen_pkg.sv
// Shared XGMII constants, FSM state encoding and the 64-bit-wide reflected
// Ethernet CRC-32 step used by the test-frame generator.
package xgmii_pktgen_pkg;

    localparam logic [7:0]  XGMII_IDLE      = 8'h07;
    localparam logic [7:0]  XGMII_START     = 8'hfb;
    localparam logic [7:0]  XGMII_TERM      = 8'hfd;
    localparam logic [7:0]  XGMII_ERROR     = 8'hfe;
    localparam logic [63:0] XGMII_IDLE_WORD = 64'h0707070707070707;
    localparam logic [63:0] XGMII_PREAMBLE  = 64'hd5555555555555fb;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_FCS,
        ST_GAP
    } state_e;

    // Lane 0 goes first and each byte is consumed LSB first.
    function automatic logic [31:0] crc32_next64(input logic [31:0] crc,
                                                 input logic [63:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 64; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hedb88320;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/xgmii_pktgen_crc64.sv
// Registered Ethernet CRC-32 consuming one 64-bit word per enabled cycle.
// fcs_next is the complemented next-state CRC, ready to place on the wire.
module xgmii_crc64
    import xgmii_pktgen_pkg::*;
(
    input  logic        xgemac_clk_156,
    input  logic        sys_rst,
    input  logic        clr,
    input  logic        en,
    input  logic [63:0] data,
    output logic [31:0] fcs_next
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_step;

    always_comb begin
        crc_step = crc32_next64(crc_q, data);
        crc_d    = crc_q;
        if (clr)     crc_d = 32'hffffffff;
        else if (en) crc_d = crc_step;
    end

    assign fcs_next = ~crc_step;

    always_ff @(posedge xgemac_clk_156 or posedge sys_rst) begin
        if (sys_rst) crc_q <= 32'hffffffff;
        else         crc_q <= crc_d;
    end

endmodule

// File: rtl/xgmii_pktgen.sv
// 10GbE test-frame generator: bursts or continuous frames carrying a sequence
// number and transmit timestamp, with a CRC-32 FCS, on one 64-bit XGMII lane set.
//
//   state | meaning
//   IDLE  | idle words, waiting for start
//   PRE   | start/preamble word
//   DATA  | header words then byte-index payload
//   FCS   | FCS in lanes 0-3, terminate in lane 4
//   GAP   | inter-frame idle words
module xgmii_pktgen
    import xgmii_pktgen_pkg::*;
#(
    parameter logic [47:0] DST_MAC   = 48'hffffffffffff,
    parameter logic [47:0] SRC_MAC   = 48'h001122334455,
    parameter logic [15:0] ETHERTYPE = 16'h88b5,
    parameter int          MAX_WORDS = 190
)(
    input  logic        xgemac_clk_156,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  cfg_frame_words,
    input  logic [7:0]  cfg_ifg_words,
    input  logic [31:0] cfg_burst,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic        busy,
    output logic        done,
    output logic [31:0] ts_count,
    output logic [31:0] tx_frames
);

    localparam logic [7:0] MAX_W     = 8'(MAX_WORDS);
    localparam logic [7:0] MIN_FRAME = 8'd8;
    localparam logic [7:0] MIN_IFG   = 8'd2;

    state_e      state_q, state_d;
    logic        run_end_q, run_end_d;
    logic [7:0]  word_idx_q, word_idx_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  frame_words_q, frame_words_d;
    logic [7:0]  ifg_q, ifg_d;
    logic        cont_q, cont_d;
    logic [31:0] burst_rem_q, burst_rem_d;
    logic        stop_seen_q, stop_seen_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] ts_q, ts_d;
    logic [31:0] ts_count_q, ts_count_d;
    logic [31:0] tx_frames_q, tx_frames_d;
    logic [63:0] txd_q, txd_d;
    logic [7:0]  txc_q, txc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [7:0]       frame_clamp, ifg_clamp;
    logic             start_ok, stop_eff, last_word, burst_hit;
    logic [7:0][7:0]  data_bytes;
    logic [63:0]      data_word;
    logic [31:0]      fcs_next;

    always_comb begin
        frame_clamp = cfg_frame_words;
        if (cfg_frame_words < MIN_FRAME)  frame_clamp = MIN_FRAME;
        else if (cfg_frame_words > MAX_W) frame_clamp = MAX_W;
        ifg_clamp = (cfg_ifg_words < MIN_IFG) ? MIN_IFG : cfg_ifg_words;
    end

    // A start landing while the last gap word is still on the wire is dropped.
    assign start_ok  = start && !run_end_q;
    assign stop_eff  = stop_seen_q | stop;
    assign last_word = (word_idx_q == frame_words_q - 8'd1);
    assign burst_hit = !cont_q && (burst_rem_q == 32'd0);

    always_ff @(posedge xgemac_clk_156 or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            run_end_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_end_q <= run_end_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_end_d = 1'b0;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_PRE;
            ST_PRE:  state_d = ST_DATA;
            ST_DATA: if (last_word) state_d = ST_FCS;
            ST_FCS:  state_d = ST_GAP;
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) begin
                    if (burst_hit || stop_eff) begin
                        state_d   = ST_IDLE;
                        run_end_d = 1'b1;
                    end else begin
                        state_d = ST_PRE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word_idx_d    = word_idx_q;
        gap_cnt_d     = gap_cnt_q;
        frame_words_d = frame_words_q;
        ifg_d         = ifg_q;
        cont_d        = cont_q;
        burst_rem_d   = burst_rem_q;
        stop_seen_d   = stop_eff;
        seq_d         = seq_q;
        ts_d          = ts_q;
        tx_frames_d   = tx_frames_q;
        ts_count_d    = ts_count_q + 32'd1;
        case (state_q)
            ST_IDLE: begin
                stop_seen_d = 1'b0;
                if (start_ok) begin
                    frame_words_d = frame_clamp;
                    ifg_d         = ifg_clamp;
                    cont_d        = (cfg_burst == 32'd0);
                    burst_rem_d   = cfg_burst;
                    seq_d         = 32'd0;
                    stop_seen_d   = stop;
                end
            end
            ST_PRE: begin
                word_idx_d = 8'd0;
                ts_d       = ts_count_q + 32'd1;
            end
            // Hold the index on the last word so the FCS cycle still sees it.
            ST_DATA: if (!last_word) word_idx_d = word_idx_q + 8'd1;
            ST_FCS: begin
                gap_cnt_d   = ifg_q - 8'd1;
                seq_d       = seq_q + 32'd1;
                tx_frames_d = tx_frames_q + 32'd1;
                if (!cont_q) burst_rem_d = burst_rem_q - 32'd1;
            end
            ST_GAP: begin
                if (gap_cnt_q == 8'd0) stop_seen_d = 1'b0;
                else                   gap_cnt_d   = gap_cnt_q - 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge xgemac_clk_156 or posedge sys_rst) begin
        if (sys_rst) begin
            word_idx_q    <= 8'd0;
            gap_cnt_q     <= 8'd0;
            frame_words_q <= MIN_FRAME;
            ifg_q         <= MIN_IFG;
            cont_q        <= 1'b0;
            burst_rem_q   <= 32'd0;
            stop_seen_q   <= 1'b0;
            seq_q         <= 32'd0;
            ts_q          <= 32'd0;
            ts_count_q    <= 32'd0;
            tx_frames_q   <= 32'd0;
        end else begin
            word_idx_q    <= word_idx_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_words_q <= frame_words_d;
            ifg_q         <= ifg_d;
            cont_q        <= cont_d;
            burst_rem_q   <= burst_rem_d;
            stop_seen_q   <= stop_seen_d;
            seq_q         <= seq_d;
            ts_q          <= ts_d;
            ts_count_q    <= ts_count_d;
            tx_frames_q   <= tx_frames_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) data_bytes[i] = {word_idx_q[4:0], 3'(i)};
        case (word_idx_q)
            8'd0: begin
                for (int i = 0; i < 6; i++) data_bytes[i] = DST_MAC[47-8*i -: 8];
                data_bytes[6] = SRC_MAC[47:40];
                data_bytes[7] = SRC_MAC[39:32];
            end
            8'd1: begin
                for (int i = 0; i < 4; i++) data_bytes[i] = SRC_MAC[31-8*i -: 8];
                data_bytes[4] = ETHERTYPE[15:8];
                data_bytes[5] = ETHERTYPE[7:0];
                data_bytes[6] = seq_q[31:24];
                data_bytes[7] = seq_q[23:16];
            end
            8'd2: begin
                data_bytes[0] = seq_q[15:8];
                data_bytes[1] = seq_q[7:0];
                for (int i = 0; i < 4; i++) data_bytes[2+i] = ts_q[31-8*i -: 8];
                data_bytes[6] = 8'h00;
                data_bytes[7] = 8'h00;
            end
            default: ;
        endcase
    end

    assign data_word = data_bytes;

    xgmii_crc64 u_crc (
        .xgemac_clk_156 (xgemac_clk_156),
        .sys_rst        (sys_rst),
        .clr            (state_q == ST_PRE),
        .en             ((state_q == ST_DATA) && !last_word),
        .data           (data_word),
        .fcs_next       (fcs_next)
    );

    always_comb begin
        txd_d  = XGMII_IDLE_WORD;
        txc_d  = 8'hff;
        busy_d = (state_q != ST_IDLE);
        done_d = run_end_q;
        case (state_q)
            ST_PRE: begin
                txd_d = XGMII_PREAMBLE;
                txc_d = 8'h01;
            end
            ST_DATA: begin
                txd_d = data_word;
                txc_d = 8'h00;
            end
            ST_FCS: begin
                txd_d = {XGMII_IDLE, XGMII_IDLE, XGMII_IDLE, XGMII_TERM, fcs_next};
                txc_d = 8'hf0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge xgemac_clk_156 or posedge sys_rst) begin
        if (sys_rst) begin
            txd_q  <= XGMII_IDLE_WORD;
            txc_q  <= 8'hff;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            txd_q  <= txd_d;
            txc_q  <= txc_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign xgmii_txd = txd_q;
    assign xgmii_txc = txc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ts_count  = ts_count_q;
    assign tx_frames = tx_frames_q;

endmodule

// File: tb/tb_xgmii_pktgen.sv
// Directed self-checking bench for xgmii_pktgen: frame content, FCS residue,
// burst/continuous/stop behaviour, clamping, reset and ignored starts.
module tb_xgmii_pktgen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  cfg_frame_words = 8'd8;
    logic [7:0]  cfg_ifg_words = 8'd2;
    logic [31:0] cfg_burst = 32'd1;
    logic [63:0] txd;
    logic [7:0]  txc;
    logic        busy, done;
    logic [31:0] ts_count, tx_frames;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hd5555555555555fb;

    xgmii_pktgen dut (
        .xgemac_clk_156  (clk),
        .sys_rst         (rst),
        .start           (start),
        .stop            (stop),
        .cfg_frame_words (cfg_frame_words),
        .cfg_ifg_words   (cfg_ifg_words),
        .cfg_burst       (cfg_burst),
        .xgmii_txd       (txd),
        .xgmii_txc       (txc),
        .busy            (busy),
        .done            (done),
        .ts_count        (ts_count),
        .tx_frames       (tx_frames)
    );

    always #3 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] wbuf [0:255];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in;
        for (int k = 0; k < 8; k++) c = (c[0] ^ b[k]) ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
        return c;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", txd, IDLE_W);
        chk("rst_txc", txc, 8'hff);
        chk("rst_busy", busy, 0);
        chk("rst_frames", tx_frames, 0);
        chk("rst_ts", ts_count, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for a preamble, captures the data words and checks the FCS word.
    task automatic grab_frame(input int pulse_at, input bit pulse_stop, output int nw,
                              output logic [31:0] seq_o, output logic [31:0] ts_pre,
                              output int pre_t);
        int guard = 0;
        int bad = 0;
        logic [31:0] c;
        logic [31:0] ts_o;
        nw = 0; seq_o = 0; ts_pre = 0; pre_t = 0;
        while (!(txc === 8'h01 && txd === PRE_W) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            chk("pre_timeout", 0, 1);
            return;
        end
        ts_pre = ts_count;
        pre_t = cyc;
        chk("pre_busy", busy, 1);
        @(negedge clk);
        while (txc === 8'h00 && nw < 256) begin
            wbuf[nw] = txd;
            start = 1'b0;
            stop = 1'b0;
            if (nw == pulse_at) begin
                if (pulse_stop) stop = 1'b1;
                else start = 1'b1;
            end
            nw++;
            @(negedge clk);
        end
        start = 1'b0;
        stop = 1'b0;
        chk("fcs_txc", txc, 8'hf0);
        chk("fcs_term", txd[63:32], 32'h070707fd);
        c = 32'hffffffff;
        for (int w = 0; w < nw; w++)
            for (int l = 0; l < 8; l++) c = crc_byte(c, wbuf[w][8*l +: 8]);
        for (int l = 0; l < 4; l++) c = crc_byte(c, txd[8*l +: 8]);
        chk("residue", c, 32'hdebb20e3);
        chk("w1", wbuf[0], 64'h1100ffffffffffff);
        chk("w2_hdr", wbuf[1][47:0], 48'hb58855443322);
        chk("w3_pad", wbuf[2][63:48], 16'h0000);
        seq_o = {wbuf[1][55:48], wbuf[1][63:56], wbuf[2][7:0], wbuf[2][15:8]};
        ts_o  = {wbuf[2][23:16], wbuf[2][31:24], wbuf[2][39:32], wbuf[2][47:40]};
        chk("ts_field", ts_o, ts_pre);
        for (int w = 3; w < nw; w++)
            for (int l = 0; l < 8; l++)
                if (wbuf[w][8*l +: 8] !== 8'((8*w + l))) bad++;
        chk("payload", bad, 0);
    endtask

    task automatic count_gap(output int n, output bit saw_done, output bit busy_at_done);
        n = 0;
        saw_done = 1'b0;
        busy_at_done = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 300; g++) begin
            if (done === 1'b1) begin
                saw_done = 1'b1;
                busy_at_done = busy;
                break;
            end
            if (txc === 8'h01) break;
            if (txc === 8'hff && txd === IDLE_W) n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nw, pre_t, prev_pre, gap;
        logic [31:0] sq, tsp, prev_ts;
        bit dn, bz;

        // single frame, start latency
        do_reset();
        cfg_frame_words = 8; cfg_ifg_words = 2; cfg_burst = 1;
        pulse_start();
        chk("lat_idle", txd, IDLE_W);
        chk("lat_busy0", busy, 0);
        @(negedge clk);
        chk("lat_pre", txd, PRE_W);
        chk("lat_prec", txc, 8'h01);
        chk("lat_busy1", busy, 1);
        grab_frame(-1, 0, nw, sq, tsp, pre_t);
        chk("t1_words", nw, 8);
        chk("t1_seq", sq, 0);
        count_gap(gap, dn, bz);
        chk("t1_gap", gap, 2);
        chk("t1_done", dn, 1);
        chk("t1_busy_done", bz, 0);
        chk("t1_frames", tx_frames, 1);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);

        // burst of 3
        do_reset();
        cfg_frame_words = 10; cfg_ifg_words = 3; cfg_burst = 3;
        pulse_start();
        prev_pre = 0; prev_ts = 0;
        for (int i = 0; i < 3; i++) begin
            grab_frame(-1, 0, nw, sq, tsp, pre_t);
            chk("t2_words", nw, 10);
            chk("t2_seq", sq, i);
            if (i > 0) begin
                chk("t2_period", pre_t - prev_pre, 15);
                chk("t2_ts_delta", tsp - prev_ts, 15);
            end
            prev_pre = pre_t;
            prev_ts = tsp;
            count_gap(gap, dn, bz);
            chk("t2_gap", gap, 3);
            chk("t2_done", dn, (i == 2));
        end
        chk("t2_frames", tx_frames, 3);

        // continuous, stop during frame 4 data
        do_reset();
        cfg_frame_words = 8; cfg_ifg_words = 2; cfg_burst = 0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            grab_frame((i == 3) ? 2 : -1, 1, nw, sq, tsp, pre_t);
            chk("t3_seq", sq, i);
            count_gap(gap, dn, bz);
            chk("t3_gap", gap, 2);
            chk("t3_done", dn, (i == 3));
        end
        chk("t3_frames", tx_frames, 4);

        // clamping
        do_reset();
        cfg_frame_words = 3; cfg_ifg_words = 0; cfg_burst = 1;
        pulse_start();
        grab_frame(-1, 0, nw, sq, tsp, pre_t);
        chk("t4_min_words", nw, 8);
        count_gap(gap, dn, bz);
        chk("t4_min_gap", gap, 2);
        chk("t4_done", dn, 1);
        do_reset();
        cfg_frame_words = 255; cfg_ifg_words = 2; cfg_burst = 1;
        pulse_start();
        grab_frame(-1, 0, nw, sq, tsp, pre_t);
        chk("t4_max_words", nw, 190);

        // reset mid-frame
        do_reset();
        cfg_frame_words = 20; cfg_ifg_words = 2; cfg_burst = 1;
        pulse_start();
        repeat (5) @(negedge clk);
        chk("t5_in_data", txc, 8'h00);
        rst = 1'b1;
        #1;
        chk("t5_rst_txd", txd, IDLE_W);
        chk("t5_rst_txc", txc, 8'hff);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ts", ts_count, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        grab_frame(-1, 0, nw, sq, tsp, pre_t);
        chk("t5_seq", sq, 0);
        chk("t5_words", nw, 20);

        // start while busy is ignored
        do_reset();
        cfg_frame_words = 8; cfg_ifg_words = 2; cfg_burst = 2;
        pulse_start();
        grab_frame(3, 0, nw, sq, tsp, pre_t);
        chk("t6_seq0", sq, 0);
        count_gap(gap, dn, bz);
        chk("t6_done0", dn, 0);
        grab_frame(-1, 0, nw, sq, tsp, pre_t);
        chk("t6_seq1", sq, 1);
        count_gap(gap, dn, bz);
        chk("t6_done1", dn, 1);
        repeat (10) @(negedge clk);
        chk("t6_busy_after", busy, 0);
        chk("t6_frames", tx_frames, 2);

        // start and stop together: exactly one frame
        do_reset();
        cfg_frame_words = 8; cfg_ifg_words = 2; cfg_burst = 0;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        grab_frame(-1, 0, nw, sq, tsp, pre_t);
        chk("t7_seq", sq, 0);
        count_gap(gap, dn, bz);
        chk("t7_done", dn, 1);
        chk("t7_frames", tx_frames, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
